// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier with STEP bits retired per cycle, per-op signedness,
// valid/ready handshakes and a synchronous flush.
module iter_multiplier #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 mul_clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mul_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int K  = WIDTH / STEP;
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;

    logic [WIDTH-1:0]     xMag;
    logic [WIDTH-1:0]     yMag;
    logic [2*WIDTH-1:0]   partial;

    // The most negative value negates onto itself, which read as unsigned is its exact magnitude.
    assign xMag = (mul_signed && x[WIDTH-1]) ? -x : x;
    assign yMag = (mul_signed && y[WIDTH-1]) ? -y : y;

    // mcand_q is pre-shifted each cycle, so it already carries the (K-cnt)*STEP weight.
    always_comb begin
        partial = '0;
        for (int j = 0; j < STEP; j++) begin
            if (mplier_q[j]) begin
                partial = partial + (mcand_q << j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        result_d = result_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_d  = {{WIDTH{1'b0}}, xMag};
                        mplier_d = yMag;
                        neg_d    = mul_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        acc_d    = '0;
                        cnt_d    = CW'(K);
                        state_d  = CALC;
                    end
                end
                CALC: begin
                    acc_d    = acc_q + partial;
                    mcand_d  = mcand_q << STEP;
                    mplier_d = mplier_q >> STEP;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = SIGN;
                    end
                end
                SIGN: begin
                    result_d = neg_q ? -acc_q : acc_q;
                    state_d  = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Scoreboard bench for iter_multiplier: directed vectors push expected products,
// a negedge monitor pops and compares on every output handshake.
module tb_iter_multiplier;

    localparam int W    = 32;
    localparam int STEP = 1;
    localparam int K    = W / STEP;

    logic            mul_clk;
    logic            resetn;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            mul_signed;
    logic [W-1:0]    x;
    logic [W-1:0]    y;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  result;

    logic [2*W-1:0]  expQ[$];
    int              nChecks = 0;
    int              nFail   = 0;

    iter_multiplier #(.WIDTH(W), .STEP(STEP)) dut (
        .mul_clk    (mul_clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mul_signed (mul_signed),
        .x          (x),
        .y          (y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result)
    );

    initial mul_clk = 1'b0;
    always #5 mul_clk = ~mul_clk;

    task automatic checkOutput(input string name, input logic [2*W-1:0] actual, input logic [2*W-1:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every completed handshake must match the oldest outstanding expectation.
    always @(negedge mul_clk) begin
        if (resetn && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpectedResult: got 0x%016h, expected no output at %0t", result, $time);
            end else begin
                checkOutput("result", result, expQ.pop_front());
            end
        end
    end

    // Returns #1 after the accept edge with in_valid dropped.
    task automatic acceptOnly(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic sv);
        int n;
        n = 0;
        @(posedge mul_clk);
        #1;
        while (!in_ready && n < 200) begin
            @(posedge mul_clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL inReadyTimeout: got in_ready=0, expected 1 within 200 cycles");
        end
        in_valid   = 1'b1;
        x          = xv;
        y          = yv;
        mul_signed = sv;
        @(posedge mul_clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issues one op, checks latency counted with the accept edge as edge 1, and
    // completes the handshake when out_ready is high; otherwise returns at the
    // negedge where out_valid was first seen.
    task automatic applyStimulus(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic sv,
                                 input logic [2*W-1:0] expv, input bit flipSign);
        int lat;
        expQ.push_back(expv);
        acceptOnly(xv, yv, sv);
        if (flipSign) mul_signed = ~sv;
        lat = 1;
        while (lat < 200) begin
            @(negedge mul_clk);
            if (out_valid) break;
            @(posedge mul_clk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(K + 2));
        if (out_ready) begin
            @(posedge mul_clk);
            #1;
        end
    endtask

    task automatic expectSilence(input string name, input int cycles);
        bit sawValid;
        sawValid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge mul_clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput(name, 64'(sawValid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn     = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        mul_signed = 1'b0;
        x          = '0;
        y          = '0;
        out_ready  = 1'b1;

        repeat (3) @(posedge mul_clk);
        #1;
        checkOutput("resetInReady", 64'(in_ready), 64'd1);
        checkOutput("resetOutValid", 64'(out_valid), 64'd0);
        checkOutput("resetResult", result, 64'd0);
        @(negedge mul_clk);
        resetn = 1'b1;

        $display("[TB] directed products");
        applyStimulus(32'd3,         32'd5,         1'b0, 64'h0000_0000_0000_000F, 1'b0);
        applyStimulus(32'hFFFF_FFF9, 32'd6,         1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b0);
        applyStimulus(32'd0,         32'hFFFF_FFFB, 1'b1, 64'h0000_0000_0000_0000, 1'b0);
        applyStimulus(32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000, 1'b0);
        applyStimulus(32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b1);
        applyStimulus(32'd12345,     32'd678,       1'b0, 64'h0000_0000_007F_B6F6, 1'b0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(32'd100, 32'd200, 1'b0, 64'h0000_0000_0000_4E20, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge mul_clk);
            @(negedge mul_clk);
            checkOutput("holdResult", result, 64'h4E20);
            checkOutput("holdHandshake", 64'({out_valid, in_ready}), 64'b10);
        end
        @(posedge mul_clk);
        #1;
        out_ready = 1'b1;
        @(posedge mul_clk);
        #1;
        checkOutput("releaseInReady", 64'(in_ready), 64'd1);
        checkOutput("releaseOutValid", 64'(out_valid), 64'd0);

        $display("[TB] flush mid-calculation");
        acceptOnly(32'h1234, 32'h10, 1'b0);
        repeat (9) @(posedge mul_clk);
        #1;
        flush = 1'b1;
        @(posedge mul_clk);
        #1;
        flush = 1'b0;
        checkOutput("flushInReady", 64'(in_ready), 64'd1);
        checkOutput("flushOutValid", 64'(out_valid), 64'd0);
        expectSilence("flushNoOutput", K + 8);
        applyStimulus(32'd2, 32'd3, 1'b0, 64'd6, 1'b0);

        $display("[TB] flush with in_valid in idle");
        @(posedge mul_clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        x        = 32'd5;
        y        = 32'd5;
        @(posedge mul_clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flushBlocksAccept", 64'(in_ready), 64'd1);
        expectSilence("flushIdleNoOutput", K + 8);

        $display("[TB] reset mid-calculation");
        acceptOnly(32'd7, 32'd9, 1'b0);
        repeat (5) @(posedge mul_clk);
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("midResetInReady", 64'(in_ready), 64'd1);
        checkOutput("midResetOutValid", 64'(out_valid), 64'd0);
        checkOutput("midResetResult", result, 64'd0);
        @(negedge mul_clk);
        resetn = 1'b1;
        applyStimulus(32'd7, 32'd9, 1'b0, 64'd63, 1'b0);

        repeat (3) @(posedge mul_clk);
        checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
